cursor_motion_ctrl: RTL and testbench

CURSOR_MOTION_CTRL -- requirements
Module: cursor_motion_ctrl

---
 rtl/cursor_motion_ctrl_if.sv | 26 ++
 rtl/cursor_motion_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cursor_motion_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cursor_motion_ctrl_if.sv
// Cursor controller signal bundle: sync/button/trace inputs and cursor outputs.
interface cursor_motion_ctrl_if;
   logic        vs_n;
   logic        up;
   logic        down;
   logic        left;
   logic        right;
   logic        trace_en;
   logic        clear_trace;
   logic [8:0]  cursor_row;
   logic [9:0]  cursor_col;
   logic [3:0]  cell_idx;
   logic [15:0] trace_mask;
   logic        frame_tick;
   logic        moving;

   modport master (
      output vs_n, up, down, left, right, trace_en, clear_trace,
      input  cursor_row, cursor_col, cell_idx, trace_mask, frame_tick, moving
   );

   modport slave (
      input  vs_n, up, down, left, right, trace_en, clear_trace,
      output cursor_row, cursor_col, cell_idx, trace_mask, frame_tick, moving
   );
endinterface

// File: rtl/cursor_motion_ctrl.sv
// Frame-paced cursor mover with auto-repeat, 4x4 cell lookup and visited-cell trace.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no direction held; first effective press steps immediately
// S_DELAY  | first step taken, counting frames to the first repeat
// S_REPEAT | auto-repeating, one step every REPEAT_RATE frames
module cursor_motion_ctrl #(
   parameter int STEP         = 4,
   parameter int REPEAT_DELAY = 15,
   parameter int REPEAT_RATE  = 2
) (
   input logic                  iVGA_CLK,
   input logic                  iRST_n,
   cursor_motion_ctrl_if.slave  bus
);
   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [10:0]      STEP_W   = 11'(STEP);
   localparam logic [10:0]      ROW_MIN  = 11'd40;
   localparam logic [10:0]      ROW_MAX  = 11'd439;
   localparam logic [10:0]      COL_MIN  = 11'd120;
   localparam logic [10:0]      COL_MAX  = 11'd519;

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             step;

   logic [3:0]  btn_meta, btn_sync;   // {up, down, left, right}
   logic        vs_meta, vs_sync, vs_sync_d;
   logic        frame_tick;
   logic        eff_up, eff_down, eff_left, eff_right, any_dir;

   logic [8:0]  cursor_row;
   logic [9:0]  cursor_col;
   logic [10:0] row_ext, col_ext, row_nx, col_nx;
   logic [1:0]  row_q, col_q;
   logic [3:0]  cell_idx;
   logic [15:0] trace_mask;

   // Two-flop synchronizers; vs_n idles high so its chain resets to 1.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         btn_meta  <= '0;
         btn_sync  <= '0;
         vs_meta   <= 1'b1;
         vs_sync   <= 1'b1;
         vs_sync_d <= 1'b1;
      end else begin
         btn_meta  <= {bus.up, bus.down, bus.left, bus.right};
         btn_sync  <= btn_meta;
         vs_meta   <= bus.vs_n;
         vs_sync   <= vs_meta;
         vs_sync_d <= vs_sync;
      end
   end

   assign frame_tick = vs_sync_d & ~vs_sync;

   // Opposing buttons cancel on their axis.
   assign eff_up    = btn_sync[3] & ~btn_sync[2];
   assign eff_down  = btn_sync[2] & ~btn_sync[3];
   assign eff_left  = btn_sync[1] & ~btn_sync[0];
   assign eff_right = btn_sync[0] & ~btn_sync[1];
   assign any_dir   = eff_up | eff_down | eff_left | eff_right;

   // FSM state and frame counter registers.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state, counter reload and step decision; only acts on frame ticks.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      step     = 1'b0;
      case (state)
         S_IDLE: begin
            if (frame_tick && any_dir) begin
               step     = 1'b1;
               cnt_nx   = DELAY_LD;
               state_nx = S_DELAY;
            end
         end
         S_DELAY, S_REPEAT: begin
            if (frame_tick) begin
               if (!any_dir) begin
                  state_nx = S_IDLE;
                  cnt_nx   = '0;
               end else if (cnt == CNT_ONE) begin
                  step     = 1'b1;
                  cnt_nx   = RATE_LD;
                  state_nx = S_REPEAT;
               end else begin
                  cnt_nx = cnt - CNT_ONE;
               end
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Saturating step arithmetic; bounds are checked before subtracting so nothing wraps.
   always_comb begin
      row_ext = {2'b00, cursor_row};
      col_ext = {1'b0, cursor_col};
      row_nx  = row_ext;
      col_nx  = col_ext;
      if (eff_up)
         row_nx = (row_ext < ROW_MIN + STEP_W) ? ROW_MIN : row_ext - STEP_W;
      else if (eff_down)
         row_nx = (row_ext + STEP_W > ROW_MAX) ? ROW_MAX : row_ext + STEP_W;
      if (eff_left)
         col_nx = (col_ext < COL_MIN + STEP_W) ? COL_MIN : col_ext - STEP_W;
      else if (eff_right)
         col_nx = (col_ext + STEP_W > COL_MAX) ? COL_MAX : col_ext + STEP_W;
   end

   // Cursor position register, updated only on a step.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         cursor_row <= 9'd240;
         cursor_col <= 10'd320;
      end else if (step) begin
         cursor_row <= 9'(row_nx);
         cursor_col <= 10'(col_nx);
      end
   end

   // 100-pixel cell bands; compares replace the divide since the range is bounded.
   assign row_q = (cursor_row >= 9'd340) ? 2'd3 :
                  (cursor_row >= 9'd240) ? 2'd2 :
                  (cursor_row >= 9'd140) ? 2'd1 : 2'd0;
   assign col_q = (cursor_col >= 10'd420) ? 2'd3 :
                  (cursor_col >= 10'd320) ? 2'd2 :
                  (cursor_col >= 10'd220) ? 2'd1 : 2'd0;

   // Cell index and visited-cell mask; clear wins over a same-cycle set.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         cell_idx   <= 4'd10;
         trace_mask <= '0;
      end else begin
         cell_idx <= {row_q, col_q};
         if (bus.clear_trace)
            trace_mask <= '0;
         else if (bus.trace_en)
            trace_mask <= trace_mask | (16'h0001 << cell_idx);
      end
   end

   assign bus.cursor_row = cursor_row;
   assign bus.cursor_col = cursor_col;
   assign bus.cell_idx   = cell_idx;
   assign bus.trace_mask = trace_mask;
   assign bus.frame_tick = frame_tick;
   assign bus.moving     = (state != S_IDLE);
endmodule

// File: tb/tb_cursor_motion_ctrl.sv
// Directed plus randomized bench for cursor_motion_ctrl against a frame-count reference model.
module tb_cursor_motion_ctrl;
   localparam int STEP = 4;
   localparam int RD   = 15;
   localparam int RR   = 2;

   logic iVGA_CLK = 1'b0;
   logic iRST_n   = 1'b1;

   cursor_motion_ctrl_if cif();

   cursor_motion_ctrl #(.STEP(STEP), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
      .iVGA_CLK (iVGA_CLK),
      .iRST_n   (iRST_n),
      .bus      (cif)
   );

   always #5 iVGA_CLK = ~iVGA_CLK;

   int tests = 0;
   int fails = 0;

   // Reference model: position, consecutive frames with a direction held, visited mask.
   int          m_row = 240;
   int          m_col = 320;
   int          m_n   = 0;
   logic [15:0] m_mask = '0;

   function automatic int m_cell();
      return ((m_row - 40) / 100) * 4 + (m_col - 120) / 100;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_row"},  32'(cif.cursor_row), 32'(m_row));
      chk({tag, "_col"},  32'(cif.cursor_col), 32'(m_col));
      chk({tag, "_cell"}, 32'(cif.cell_idx),   32'(m_cell()));
      chk({tag, "_mask"}, 32'(cif.trace_mask), 32'(m_mask));
      chk({tag, "_mov"},  32'(cif.moving),     32'(m_n > 0));
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_row"},  32'(cif.cursor_row), 32'd240);
      chk({tag, "_col"},  32'(cif.cursor_col), 32'd320);
      chk({tag, "_cell"}, 32'(cif.cell_idx),   32'd10);
      chk({tag, "_mask"}, 32'(cif.trace_mask), 32'd0);
      chk({tag, "_tick"}, 32'(cif.frame_tick), 32'd0);
      chk({tag, "_mov"},  32'(cif.moving),     32'd0);
   endtask

   // Step on the first held frame, then RD frames later, then every RR frames.
   task automatic model_tick(input logic u, input logic d, input logic l, input logic r);
      bit ru, rd, rl, rr, st;
      ru = u && !d;
      rd = d && !u;
      rl = l && !r;
      rr = r && !l;
      if (!(ru || rd || rl || rr)) begin
         m_n = 0;
         return;
      end
      m_n++;
      st = (m_n == 1) || (m_n > RD && ((m_n - 1 - RD) % RR) == 0);
      if (st) begin
         if (ru) m_row = (m_row - STEP < 40)  ? 40  : m_row - STEP;
         if (rd) m_row = (m_row + STEP > 439) ? 439 : m_row + STEP;
         if (rl) m_col = (m_col - STEP < 120) ? 120 : m_col - STEP;
         if (rr) m_col = (m_col + STEP > 519) ? 519 : m_col + STEP;
      end
   endtask

   task automatic frame(input logic u, input logic d, input logic l, input logic r, input logic ten);
      bit seen;
      seen = 1'b0;
      @(negedge iVGA_CLK);
      cif.up = u; cif.down = d; cif.left = l; cif.right = r;
      cif.trace_en = ten;
      repeat (3) @(negedge iVGA_CLK);
      if (ten) m_mask |= 16'(1 << m_cell());
      cif.vs_n = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge iVGA_CLK);
         if (cif.frame_tick) seen = 1'b1;
      end
      chk("tick_seen", 32'(seen), 32'd1);
      model_tick(u, d, l, r);
      @(negedge iVGA_CLK);
      chk("tick_width", 32'(cif.frame_tick), 32'd0);
      chk("lat1_row", 32'(cif.cursor_row), 32'(m_row));
      chk("lat1_col", 32'(cif.cursor_col), 32'(m_col));
      repeat (2) @(negedge iVGA_CLK);
      if (ten) m_mask |= 16'(1 << m_cell());
      check_all("frame");
      cif.vs_n = 1'b1;
      repeat (4) @(negedge iVGA_CLK);
      chk("hold_row", 32'(cif.cursor_row), 32'(m_row));
      chk("hold_col", 32'(cif.cursor_col), 32'(m_col));
   endtask

   task automatic clear_pulse();
      @(negedge iVGA_CLK);
      cif.clear_trace = 1'b1;
      @(negedge iVGA_CLK);
      cif.clear_trace = 1'b0;
      m_mask = '0;
      chk("clear", 32'(cif.trace_mask), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] dirs;
      logic       ten;

      cif.vs_n = 1'b1;
      cif.up = 1'b0; cif.down = 1'b0; cif.left = 1'b0; cif.right = 1'b0;
      cif.trace_en = 1'b0;
      cif.clear_trace = 1'b0;

      // Reset values appear while reset is held, before any clock edge.
      #1 iRST_n = 1'b0;
      #2 check_reset_vals("rst_async");
      repeat (3) @(negedge iVGA_CLK);
      iRST_n = 1'b1;
      repeat (2) @(negedge iVGA_CLK);
      check_all("post_rst");

      // Trace of the reset cell, then clear colliding with a set.
      cif.trace_en = 1'b1;
      repeat (2) @(negedge iVGA_CLK);
      m_mask = 16'h0400;
      chk("trace_first", 32'(cif.trace_mask), 32'h0400);
      clear_pulse();
      @(negedge iVGA_CLK);
      m_mask = 16'(1 << m_cell());
      chk("trace_reset", 32'(cif.trace_mask), 32'h0400);
      cif.trace_en = 1'b0;

      // One right step, then release.
      frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("right_col", 32'(cif.cursor_col), 32'd324);
      chk("right_mov", 32'(cif.moving), 32'd1);
      frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("release_mov", 32'(cif.moving), 32'd0);

      // Opposing vertical buttons cancel; column still moves.
      frame(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("cancel_row", 32'(cif.cursor_row), 32'd240);
      chk("cancel_col", 32'(cif.cursor_col), 32'd328);
      frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Up for 20 ticks: steps at 1, 16, 18, 20.
      for (int i = 0; i < 20; i++) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("up20_row", 32'(cif.cursor_row), 32'd224);
      frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reach REPEAT, then reset asynchronously between clock edges.
      for (int i = 0; i < 17; i++) frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_mov", 32'(cif.moving), 32'd1);
      @(negedge iVGA_CLK);
      #2 iRST_n = 1'b0;
      #1 check_reset_vals("rst_repeat");
      m_row = 240; m_col = 320; m_n = 0; m_mask = '0;
      cif.down = 1'b0;
      @(negedge iVGA_CLK);
      iRST_n = 1'b1;
      frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("restart_row", 32'(cif.cursor_row), 32'd244);

      // Long left hold saturates at the left edge.
      for (int i = 0; i < 120; i++) frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("sat_col", 32'(cif.cursor_col), 32'd120);
      chk("sat_cell", 32'(cif.cell_idx), 32'd8);
      frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized holds, direction changes, trace enables and clears.
      dirs = 4'b0000;
      ten  = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if ($urandom_range(0, 3) == 0) dirs = 4'($urandom_range(0, 15));
         if ((i % 10) == 0) ten = 1'($urandom_range(0, 1));
         frame(dirs[3], dirs[2], dirs[1], dirs[0], ten);
         if ((i % 15) == 14) clear_pulse();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
